seg_display_scan_ctrl: RTL and testbench
========================================

// Module: seg_display_scan_ctrl
// PURPOSE
//  Sequencer between the calculator result and the shared active-high BCD-to-7-segment decoder.
//  On load, converts an 8-bit magnitude plus sign flag to three BCD digits (sequential
//  double-dabble) and holds them. Continuously time-multiplexes sign/hundreds/tens/ones onto one
//  4-bit decoder input with a one-hot digit select. Decoder codes: 0-9 digit, 4'hF minus, 4'hE blank.
// PARAMETERS
//  SCAN_DIV  50000  clk cycles per digit slot (>=1; 1 = advance every cycle)
//  BLANK_LZ  1      1: blank leading zeros in hundreds/tens; 0: always show them
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  load       in   1  start conversion of value/neg; sampled only when busy=0
//  value      in   8  unsigned magnitude 0..255
//  neg        in   1  1 = display minus sign
//  busy       out  1  conversion in progress; load ignored while high
//  bcd_code   out  4  code to the shared decoder (registered)
//  digit_sel  out  4  one-hot digit enable, bit0=ones, bit1=tens, bit2=hundreds, bit3=sign (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): busy=0, digit_sel=4'b0001, bcd_code=4'hE, prescaler=0, all held display
//   digits=4'hE, FSM=IDLE. A conversion in flight is aborted; nothing is committed.
//  FSM: IDLE -load&!busy-> CONV (8 cycles) -> COMMIT (1 cycle) -> IDLE.
//   Cycle of accepted load: capture value/neg, clear 12-bit BCD shift reg. busy=1 from next cycle for
//   exactly 9 cycles (8 CONV + 1 COMMIT), 0 again on the cycle after COMMIT.
//   load during busy: ignored, no queueing. load in cycle busy falls: accepted.
//  CONV step: for each BCD nibble >=5 add 3, then shift {bcd,value_sh} left 1 (value MSB first).
//   Nibble adds never carry across nibbles; hundreds nibble never exceeds 2.
//  COMMIT: held digits updated atomically; previous result shown until then (no partial display).
//   ones = BCD[3:0] always; hundreds = (BLANK_LZ && H==0) ? 4'hE : H;
//   tens = (BLANK_LZ && H==0 && T==0) ? 4'hE : T; sign = neg ? 4'hF : 4'hE.
//  Scan: prescaler counts 0..SCAN_DIV-1 independent of FSM state. At terminal count it wraps to 0 and
//   digit index advances 0->1->2->3->0; digit_sel rotates left (4'b1000 wraps to 4'b0001).
//   bcd_code and digit_sel update in the same clk edge; they always describe the same digit.
//   bcd_code reflects the held digits, so a COMMIT changes bcd_code at the next edge without
//   disturbing the scan phase.
//  digit_sel is always exactly one-hot; bcd_code never takes values 4'hA-4'hD.
// STRUCTURE
//  Shared package/header seg_display_pkg: CODE_MINUS=4'hF, CODE_BLANK=4'hE, FSM state
//   encodings (IDLE, CONV, COMMIT), digit index constants.
//  One sub-module: bin8_to_bcd_seq (start/done, 8-bit in, 12-bit BCD out, double-dabble step/cycle).
//  Top holds the FSM glue, held digit registers, prescaler, and scan mux.
//  The decoder is instantiated by the parent, not inside this block.
// TESTING
//  1 Reset: rst_n=0 -> busy=0, digit_sel=0001, bcd_code=E; release, SCAN_DIV=4 -> all slots show E.
//  2 load value=157 neg=0 -> busy high 9 cycles; then slots ones..sign = 7,5,1,E.
//  3 load value=5 neg=1, BLANK_LZ=1 -> 5,E,E,F. Same with BLANK_LZ=0 -> 5,0,0,F.
//  4 load 255; pulse load with value=0 at busy cycle 3 -> ignored; display 5,5,2,E. Next load 0 -> 0,E,E,E.
//  5 SCAN_DIV=4: digit_sel changes every 4 cycles, sequence 0001,0010,0100,1000,0001.
//    SCAN_DIV=1 -> changes every cycle. bcd_code always matches the selected slot.
//  6 Assert rst_n mid-CONV (cycle 4 of load 200) -> outputs at reset values immediately, asynchronously.
//    After release, display stays blank and busy=0.

Source files
------------

// File: rtl/seg_display_scan_ctrl_pkg.sv
// seg_display_pkg: shared codes, FSM states and digit indices for the scan controller
package seg_display_pkg;
  localparam logic [3:0] CODE_MINUS = 4'hF;
  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;
  localparam int CONV_STEPS = 8;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg_display_scan_ctrl_if.sv
// seg_display_scan_ctrl_if: load/value/neg request with busy back-pressure
interface seg_display_scan_ctrl_if;
  logic load;
  logic [7:0] value;
  logic neg;
  logic busy;
  modport master(output load, value, neg, input busy);
  modport slave(input load, value, neg, output busy);
endinterface

// File: rtl/seg_display_scan_ctrl_bin2bcd.sv
// bin8_to_bcd_seq: sequential double-dabble, one add-3/shift step per clock
module bin8_to_bcd_seq
  import seg_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [7:0] sh;
  logic [2:0] cnt;
  logic run;
  logic [11:0] adj;
  // hundreds never exceeds 2, so dropping adj[11] on the shift loses nothing
  assign adj = {dd_adj(bcd[11:8]), dd_adj(bcd[7:4]), dd_adj(bcd[3:0])};
  // done marks the final shift cycle; bcd holds the result from the next cycle on
  assign done = run && cnt == 3'(CONV_STEPS - 1);
  // capture on start, then shift value MSB first into the adjusted BCD register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh <= bin;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, sh} <= {adj[10:0], sh, 1'b0};
      cnt <= cnt + 3'd1;
      run <= !done;
    end
  end
endmodule

// File: rtl/seg_display_scan_ctrl.sv
// seg_display_scan_ctrl: converts a signed 8-bit result to BCD and scans it onto a shared decoder
module seg_display_scan_ctrl
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_display_scan_ctrl_if.slave  bus,
  output logic [3:0]              bcd_code,
  output logic [3:0]              digit_sel
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t state;
  logic busy_r, neg_r, start, done, tc;
  logic [11:0] bcd;
  logic [3:0] h, t;
  logic [PW-1:0] psc;
  logic [1:0] idx, nidx;
  logic [3:0] held [4];
  assign start = bus.load && !busy_r;
  assign bus.busy = busy_r;
  assign h = bcd[11:8];
  assign t = bcd[7:4];
  bin8_to_bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bus.value),
    .done  (done),
    .bcd   (bcd)
  );
  // load sequencing; held digits change only in COMMIT so the display never shows a partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy_r <= 1'b0;
      neg_r <= 1'b0;
      held <= '{default: CODE_BLANK};
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CONV;
          busy_r <= 1'b1;
          neg_r <= bus.neg;
        end
        CONV: if (done) state <= COMMIT;
        COMMIT: begin
          state <= IDLE;
          busy_r <= 1'b0;
          held[DIG_ONES] <= bcd[3:0];
          held[DIG_TENS] <= (BLANK_LZ && h == 4'd0 && t == 4'd0) ? CODE_BLANK : t;
          held[DIG_HUNDREDS] <= (BLANK_LZ && h == 4'd0) ? CODE_BLANK : h;
          held[DIG_SIGN] <= neg_r ? CODE_MINUS : CODE_BLANK;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign tc = psc == PW'(SCAN_DIV - 1);
  assign nidx = tc ? idx + 2'd1 : idx;
  // free-running scan; code and select are loaded together so they always name the same digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      idx <= DIG_ONES;
      digit_sel <= 4'b0001;
      bcd_code <= CODE_BLANK;
    end else begin
      psc <= tc ? '0 : psc + PW'(1);
      idx <= nidx;
      digit_sel <= 4'b0001 << nidx;
      bcd_code <= held[nidx];
    end
  end
endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// tb_seg_display_scan_ctrl: three configurations driven in lockstep, checked against a digit-level model
module tb_seg_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ld = 1'b0;
  logic [7:0] val = 8'd0;
  logic ng = 1'b0;
  logic chk_en = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] bcd [3];
  logic [3:0] sel [3];
  logic busy_w [3];
  int div_k [3] = '{4, 4, 1};
  bit blz_k [3] = '{1'b1, 1'b0, 1'b1};
  int n;
  int mrem;
  logic [7:0] mval;
  logic mneg;
  logic [3:0] mheld [3][4];
  logic [3:0] exp_bcd [3];
  logic [3:0] exp_sel [3];
  logic exp_busy;
  logic [3:0] seq_a [16];
  logic [3:0] seq_c [16];

  always #5 clk = ~clk;

  seg_display_scan_ctrl_if ifa();
  seg_display_scan_ctrl_if ifb();
  seg_display_scan_ctrl_if ifc();
  assign ifa.load = ld;
  assign ifa.value = val;
  assign ifa.neg = ng;
  assign ifb.load = ld;
  assign ifb.value = val;
  assign ifb.neg = ng;
  assign ifc.load = ld;
  assign ifc.value = val;
  assign ifc.neg = ng;
  assign busy_w[0] = ifa.busy;
  assign busy_w[1] = ifb.busy;
  assign busy_w[2] = ifc.busy;

  seg_display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .bcd_code(bcd[0]), .digit_sel(sel[0]));
  seg_display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .bcd_code(bcd[1]), .digit_sel(sel[1]));
  seg_display_scan_ctrl #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .bcd_code(bcd[2]), .digit_sel(sel[2]));

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: display slot from elapsed edges, busy from a 9-cycle window, digits from decimal arithmetic
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0;
      mrem = 0;
      exp_busy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_bcd[k] = 4'hE;
        exp_sel[k] = 4'b0001;
        for (int d = 0; d < 4; d++) mheld[k][d] = 4'hE;
      end
    end else begin
      n++;
      for (int k = 0; k < 3; k++) begin
        int slot;
        slot = (n / div_k[k]) % 4;
        exp_sel[k] = 4'(1 << slot);
        exp_bcd[k] = mheld[k][slot];
      end
      if (mrem == 0 && ld) begin
        mrem = 9;
        mval = val;
        mneg = ng;
      end else if (mrem > 0) begin
        mrem--;
        if (mrem == 0) begin
          int hh, tt, oo;
          hh = mval / 100;
          tt = (mval / 10) % 10;
          oo = mval % 10;
          for (int k = 0; k < 3; k++) begin
            mheld[k][0] = 4'(oo);
            mheld[k][1] = (blz_k[k] && hh == 0 && tt == 0) ? 4'hE : 4'(tt);
            mheld[k][2] = (blz_k[k] && hh == 0) ? 4'hE : 4'(hh);
            mheld[k][3] = mneg ? 4'hF : 4'hE;
          end
        end
      end
      exp_busy = mrem != 0;
    end
  end

  // every-cycle comparison of all three DUTs against the model
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cyc_busy%0d", k), 16'(busy_w[k]), 16'(exp_busy));
        check($sformatf("cyc_sel%0d", k), 16'(sel[k]), 16'(exp_sel[k]));
        check($sformatf("cyc_bcd%0d", k), 16'(bcd[k]), 16'(exp_bcd[k]));
      end
  end

  task automatic do_load(input logic [7:0] v, input logic s);
    @(negedge clk);
    ld = 1'b1;
    val = v;
    ng = s;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic slot_check(input int k, input string nm, input logic [3:0] l0, input logic [3:0] l1,
                            input logic [3:0] l2, input logic [3:0] l3);
    logic [3:0] lit [4];
    lit[0] = l0;
    lit[1] = l1;
    lit[2] = l2;
    lit[3] = l3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (sel[k] == 4'(1 << j)) check($sformatf("%s_slot%0d", nm, j), 16'(bcd[k]), 16'(lit[j]));
    end
  endtask

  task automatic reset_vals(input string nm);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_busy%0d", nm, k), 16'(busy_w[k]), 16'd0);
      check($sformatf("%s_sel%0d", nm, k), 16'(sel[k]), 16'b0001);
      check($sformatf("%s_bcd%0d", nm, k), 16'(bcd[k]), 16'hE);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    seq_a = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1};
    seq_c = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    #2 rst_n = 1'b0;
    #1 reset_vals("rst_async");
    repeat (3) @(negedge clk);
    reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("seq_div4", 16'(sel[0]), 16'(seq_a[i]));
      check("seq_div1", 16'(sel[2]), 16'(seq_c[i]));
      check("blank_after_rst", 16'(bcd[0]), 16'hE);
    end
    do_load(8'd157, 1'b0);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_w[0]) c++;
      @(negedge clk);
    end
    check("busy_len", 16'(c), 16'd9);
    slot_check(0, "v157", 4'h7, 4'h5, 4'h1, 4'hE);
    slot_check(2, "v157_div1", 4'h7, 4'h5, 4'h1, 4'hE);
    do_load(8'd5, 1'b1);
    repeat (12) @(negedge clk);
    slot_check(0, "v5n_blz", 4'h5, 4'hE, 4'hE, 4'hF);
    slot_check(1, "v5n_noblz", 4'h5, 4'h0, 4'h0, 4'hF);
    do_load(8'd255, 1'b0);
    repeat (2) @(negedge clk);
    ld = 1'b1;
    val = 8'd0;
    @(negedge clk);
    ld = 1'b0;
    repeat (12) @(negedge clk);
    slot_check(0, "v255", 4'h5, 4'h5, 4'h2, 4'hE);
    do_load(8'd0, 1'b0);
    repeat (12) @(negedge clk);
    slot_check(0, "v0", 4'h0, 4'hE, 4'hE, 4'hE);
    slot_check(1, "v0_noblz", 4'h0, 4'h0, 4'h0, 4'hE);
    @(negedge clk);
    ld = 1'b1;
    val = 8'd42;
    repeat (25) @(negedge clk);
    ld = 1'b0;
    repeat (12) @(negedge clk);
    slot_check(0, "v42", 4'h2, 4'h4, 4'hE, 4'hE);
    do_load(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_vals("rst_midconv");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slot_check(0, "post_rst", 4'hE, 4'hE, 4'hE, 4'hE);
    check("post_rst_busy", 16'(busy_w[0]), 16'd0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
